// File: rtl/uart_link_arbiter.sv
// Round-robin arbiter sharing one UART frame link between NUM_REQ requesters.
// Sequences the TX handshake, waits for read responses and routes them back.
module uart_link_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int FRAME_WIDTH    = 32,
  parameter int RESP_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_is_read,
  input  logic [NUM_REQ*FRAME_WIDTH-1:0] req_frame,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [NUM_REQ-1:0]             resp_timeout,
  output logic [RESP_WIDTH-1:0]          resp_data,
  output logic                           link_busy,
  output logic [FRAME_WIDTH-1:0]         u_din,
  output logic                           u_en,
  input  logic                           u_tx_busy,
  input  logic                           u_rx_ready,
  input  logic [RESP_WIDTH-1:0]          u_dout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);
  localparam logic [15:0] CNT_MAX = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    TX_START,
    TX_WAIT,
    RX_WAIT
  } state_t;

  state_t        state;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] owner;
  logic [IW-1:0] win;
  logic          win_ok;
  logic          is_read;
  logic [15:0]   cnt;

  // Search starts just past the last grant so every requester gets a turn.
  always_comb begin
    int idx;
    idx    = 0;
    win    = '0;
    win_ok = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!win_ok && req_valid[IW'(idx)]) begin
        win_ok = 1'b1;
        win    = IW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && win_ok) begin
      req_ready[win] = 1'b1;
    end
  end

  assign link_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      last_grant   <= LAST_INIT;
      owner        <= '0;
      is_read      <= 1'b0;
      cnt          <= '0;
      u_en         <= 1'b0;
      u_din        <= '0;
      resp_data    <= '0;
      resp_valid   <= '0;
      resp_timeout <= '0;
    end else begin
      u_en         <= 1'b0;
      resp_valid   <= '0;
      resp_timeout <= '0;
      unique case (state)
        IDLE: begin
          if (win_ok) begin
            owner      <= win;
            is_read    <= req_is_read[win];
            u_din      <= req_frame[int'(win)*FRAME_WIDTH +: FRAME_WIDTH];
            last_grant <= win;
            u_en       <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          state <= TX_START;
        end
        TX_START: begin
          if (u_tx_busy) begin
            state <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (!u_tx_busy) begin
            if (is_read) begin
              cnt   <= '0;
              state <= RX_WAIT;
            end else begin
              state <= IDLE;
            end
          end
        end
        RX_WAIT: begin
          cnt <= cnt + 16'd1;
          // A response arriving on the expiry cycle beats the timeout.
          if (u_rx_ready) begin
            resp_data         <= u_dout;
            resp_valid[owner] <= 1'b1;
            state             <= IDLE;
          end else if (cnt == CNT_MAX) begin
            resp_timeout[owner] <= 1'b1;
            state               <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_link_arbiter.sv
// Directed bench for uart_link_arbiter: round-robin table plus reset,
// read routing, timeout, simultaneous-event and stray-response sequences.
module tb_uart_link_arbiter;

  localparam logic [31:0] F0 = 32'h00112345;
  localparam logic [31:0] F1 = 32'h001A5678;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  req_valid;
  logic [1:0]  req_is_read;
  logic [63:0] req_frame;
  logic        u_tx_busy;
  logic        u_rx_ready;
  logic [15:0] u_dout;

  logic [1:0]  a_ready, a_valid, a_tmo;
  logic [15:0] a_data;
  logic        a_busy, a_en;
  logic [31:0] a_din;
  logic [1:0]  b_ready, b_valid, b_tmo;
  logic [15:0] b_data;
  logic        b_busy, b_en;
  logic [31:0] b_din;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tx_len = 1;
  logic [7:0] bcnt;
  int va[2];
  int ta[2];

  always #5 clk = ~clk;

  uart_link_arbiter #(
    .NUM_REQ(2), .FRAME_WIDTH(32), .RESP_WIDTH(16), .TIMEOUT_CYCLES(32)
  ) dut_a (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_is_read(req_is_read), .req_frame(req_frame),
    .req_ready(a_ready), .resp_valid(a_valid), .resp_timeout(a_tmo),
    .resp_data(a_data), .link_busy(a_busy), .u_din(a_din), .u_en(a_en),
    .u_tx_busy(u_tx_busy), .u_rx_ready(u_rx_ready), .u_dout(u_dout)
  );

  uart_link_arbiter #(
    .NUM_REQ(2), .FRAME_WIDTH(32), .RESP_WIDTH(16), .TIMEOUT_CYCLES(8)
  ) dut_b (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_is_read(req_is_read), .req_frame(req_frame),
    .req_ready(b_ready), .resp_valid(b_valid), .resp_timeout(b_tmo),
    .resp_data(b_data), .link_busy(b_busy), .u_din(b_din), .u_en(b_en),
    .u_tx_busy(u_tx_busy), .u_rx_ready(u_rx_ready), .u_dout(u_dout)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // UART transmitter model: busy for tx_len cycles after a start pulse.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) bcnt <= 8'd0;
    else if (a_en) bcnt <= tx_len[7:0];
    else if (bcnt != 8'd0) bcnt <= bcnt - 8'd1;
  end
  assign u_tx_busy = (bcnt != 8'd0);

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (a_valid[k]) va[k] <= va[k] + 1;
      if (a_tmo[k]) ta[k] <= ta[k] + 1;
    end
  end

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  exp_ready;
    logic [31:0] exp_din;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_grant(input bit use_b, output logic [1:0] got,
                            output int gc);
    got = 2'b00;
    gc  = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if ((use_b ? b_ready : a_ready) != 2'b00) begin
        got = use_b ? b_ready : a_ready;
        gc  = cyc;
        break;
      end
    end
  endtask

  task automatic do_reset();
    req_valid   = 2'b00;
    req_is_read = 2'b00;
    u_rx_ready  = 1'b0;
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
  endtask

  initial begin
    logic [1:0] got;
    int g, prev, sv0, sv1, st;
    bit seen, done;
    tbl[0] = '{2'b11, 2'b01, F0};
    tbl[1] = '{2'b11, 2'b10, F1};
    tbl[2] = '{2'b11, 2'b01, F0};
    tbl[3] = '{2'b11, 2'b10, F1};
    tbl[4] = '{2'b10, 2'b10, F1};
    tbl[5] = '{2'b01, 2'b01, F0};
    tbl[6] = '{2'b11, 2'b10, F1};
    prev = 0;
    rstn = 1'b0;
    req_valid = 2'b00;
    req_is_read = 2'b00;
    req_frame = {F1, F0};
    u_rx_ready = 1'b0;
    u_dout = 16'h0;

    repeat (2) @(negedge clk);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_en", a_en, 1'b0);
    chk("rst_din", a_din, 32'h0);
    chk("rst_data", a_data, 16'h0);
    chk("rst_valid", a_valid, 2'b00);
    chk("rst_tmo", a_tmo, 2'b00);
    @(posedge clk); #1 rstn = 1'b1;

    // Reset asserted mid-TX_WAIT on a frame from requester 0.
    tx_len = 8;
    req_valid = 2'b01;
    wait_grant(1'b0, got, g);
    chk("pre_grant", got, 2'b01);
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (4) @(negedge clk);
    chk("pre_busy", a_busy, 1'b1);
    chk("pre_din", a_din, F0);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_busy", a_busy, 1'b0);
    chk("mid_rst_din", a_din, 32'h0);
    chk("mid_rst_en", a_en, 1'b0);
    chk("mid_rst_valid", a_valid | a_tmo, 2'b00);
    @(posedge clk); @(posedge clk); #1 rstn = 1'b1;
    tx_len = 1;

    for (int i = 0; i < 7; i++) begin
      req_valid = tbl[i].valid;
      wait_grant(1'b0, got, g);
      chk($sformatf("rr%0d_ready", i), got, tbl[i].exp_ready);
      if (i > 0) chk($sformatf("rr%0d_gap", i), g - prev, 4);
      prev = g;
      @(posedge clk); #1;
      chk($sformatf("rr%0d_en", i), a_en, 1'b1);
      chk($sformatf("rr%0d_din", i), a_din, tbl[i].exp_din);
      chk($sformatf("rr%0d_busy", i), a_busy, 1'b1);
    end
    req_valid = 2'b00;
    repeat (6) @(posedge clk);

    // Read from requester 1, response 20 cycles after TX ends.
    do_reset();
    tx_len = 3;
    req_valid = 2'b10;
    req_is_read = 2'b10;
    wait_grant(1'b0, got, g);
    chk("rd_grant", got, 2'b10);
    @(posedge clk); #1;
    req_valid = 2'b00;
    req_is_read = 2'b00;
    sv0 = va[0];
    sv1 = va[1];
    st = ta[0] + ta[1];
    seen = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (u_tx_busy) seen = 1'b1;
      else if (seen) begin
        done = 1'b1;
        break;
      end
    end
    chk("rd_txend", done, 1'b1);
    repeat (20) @(posedge clk);
    #1 u_rx_ready = 1'b1;
    u_dout = 16'h00C3;
    @(posedge clk); #1 u_rx_ready = 1'b0;
    u_dout = 16'h0;
    @(negedge clk);
    chk("rd_valid", a_valid, 2'b10);
    chk("rd_data", a_data, 16'h00C3);
    @(negedge clk);
    chk("rd_pulse_end", a_valid, 2'b00);
    chk("rd_idle", a_busy, 1'b0);
    @(posedge clk); #1;
    chk("rd_cnt1", va[1] - sv1, 1);
    chk("rd_cnt0", va[0] - sv0, 0);
    chk("rd_no_tmo", ta[0] + ta[1] - st, 0);

    // Timeout of 8 cycles on a read from requester 0.
    do_reset();
    tx_len = 1;
    req_valid = 2'b01;
    req_is_read = 2'b01;
    wait_grant(1'b1, got, g);
    chk("to_grant", got, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b11;
    req_is_read = 2'b00;
    repeat (11) @(negedge clk);
    chk("to_early", b_tmo, 2'b00);
    @(negedge clk);
    chk("to_pulse", b_tmo, 2'b01);
    chk("to_idle", b_busy, 1'b0);
    chk("to_next", b_ready, 2'b10);
    chk("to_novalid", b_valid, 2'b00);

    // Response on the expiry cycle of the 8-cycle timeout.
    do_reset();
    tx_len = 1;
    req_valid = 2'b01;
    req_is_read = 2'b01;
    wait_grant(1'b1, got, g);
    chk("sim_grant", got, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    req_is_read = 2'b00;
    repeat (10) @(posedge clk);
    #1 u_rx_ready = 1'b1;
    u_dout = 16'h5A5A;
    @(posedge clk); #1 u_rx_ready = 1'b0;
    u_dout = 16'h0;
    @(negedge clk);
    chk("sim_valid", b_valid, 2'b01);
    chk("sim_tmo", b_tmo, 2'b00);
    chk("sim_data", b_data, 16'h5A5A);
    @(negedge clk);
    chk("sim_tmo_late", b_tmo, 2'b00);

    // Stray responses while idle and while transmitting a write.
    @(posedge clk); #1 u_rx_ready = 1'b1;
    u_dout = 16'hFFFF;
    @(posedge clk); #1 u_rx_ready = 1'b0;
    u_dout = 16'h0;
    @(negedge clk);
    chk("st_idle_valid", a_valid, 2'b00);
    chk("st_idle_data", a_data, 16'h5A5A);
    @(posedge clk); #1;
    sv0 = va[0];
    sv1 = va[1];
    tx_len = 6;
    req_valid = 2'b10;
    wait_grant(1'b0, got, g);
    chk("st_grant", got, 2'b10);
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (3) @(posedge clk);
    #1 u_rx_ready = 1'b1;
    u_dout = 16'hBEEF;
    chk("st_txwait", a_busy, 1'b1);
    @(posedge clk); #1 u_rx_ready = 1'b0;
    u_dout = 16'h0;
    repeat (8) @(posedge clk);
    #1;
    chk("st_done", a_busy, 1'b0);
    chk("st_data", a_data, 16'h5A5A);
    chk("st_cnt", (va[0] - sv0) + (va[1] - sv1), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_link_arbiter.md
# uart_link_arbiter

Shares the single bus-bridge UART link (32-bit TX frame, 16-bit RX response) between up to four local requesters, e.g. several bus-bridge slave ports or a bridge plus a debug/config port. Grants one requester at a time in round-robin order, drives the UART transmit handshake, and waits for the UART response on read frames. Routes each response back to the requester that issued it. Bounds every read wait with a timeout counter so a lost response cannot lock the link.

## Interface
Parameters:
- NUM_REQ, 2 — number of requesters, legal range 1..4.
- FRAME_WIDTH, 32 — TX frame width, matches the UART transmit data input.
- RESP_WIDTH, 16 — RX response width, matches the UART receive data output.
- TIMEOUT_CYCLES, 65535 — maximum cycles to wait for a read response; legal range 1..65535; 16-bit counter.

Ports:
- clk  in  1  — single clock for the whole block.
- rstn  in  1  — reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  — requester i has a frame pending; held until accepted.
- req_is_read  in  NUM_REQ  — requester i's frame expects a UART response.
- req_frame  in  NUM_REQ*FRAME_WIDTH  — requester i's frame, on bits [i*FRAME_WIDTH +: FRAME_WIDTH].
- req_ready  out  NUM_REQ  — one-hot accept, combinational.
- resp_valid  out  NUM_REQ  — one-cycle pulse to the owner when its response is captured.
- resp_timeout  out  NUM_REQ  — one-cycle pulse to the owner when its read times out.
- resp_data  out  RESP_WIDTH  — last captured response; registered.
- link_busy  out  1  — high in every state except IDLE.
- u_din  out  FRAME_WIDTH  — frame to the UART transmitter; registered.
- u_en  out  1  — UART transmit start, one-cycle pulse.
- u_tx_busy  in  1  — UART transmitter busy.
- u_rx_ready  in  1  — UART received a response; level or pulse.
- u_dout  in  RESP_WIDTH  — UART received data.

## Operation
State machine states: IDLE, SEND, TX_START, TX_WAIT, RX_WAIT.

**IDLE**
- Arbitration is round-robin. Starting from (last_grant+1) mod NUM_REQ, the first i with req_valid[i]=1 wins.
- req_ready[i]=1 only for the winner; all other bits are 0. No grant is issued outside IDLE.
- On the grant edge, capture:
  - owner = i
  - is_read = req_is_read[i]
  - u_din = req_frame[i]
  - last_grant = i
- Next state is SEND.

**SEND**
- u_en=1 for exactly this cycle. Next state is TX_START.

**TX_START**
- Wait for u_tx_busy=1, then go to TX_WAIT.
- If u_tx_busy is already 1 in the SEND cycle, still pass through TX_START for one cycle.

**TX_WAIT**
- Wait for u_tx_busy=0.
- Then go to RX_WAIT if is_read, else to IDLE.
- Load the timeout counter with 0 on entry to RX_WAIT.

**RX_WAIT**
- The counter increments every cycle.
- If u_rx_ready=1: resp_data <= u_dout, pulse resp_valid[owner], go to IDLE.
- Else, if the counter reaches TIMEOUT_CYCLES-1: pulse resp_timeout[owner], go to IDLE.
- If u_rx_ready=1 on the same cycle the counter expires, the response wins; no timeout pulse is issued.

**Other rules**
- u_rx_ready outside RX_WAIT is ignored. The stale response is dropped; resp_data and resp_valid are unchanged.
- u_din holds its value between grants. resp_data holds until the next capture.
- A requester that drops req_valid before its grant is simply skipped. Frame contents are never inspected.
- When NUM_REQ=1, last_grant is always 0 and arbitration degenerates to fixed priority.

## Timing
**Reset** (asynchronous assert; takes effect immediately, mid-frame included):
- state=IDLE, u_en=0, u_din=0, resp_data=0.
- resp_valid=0, resp_timeout=0, link_busy=0, counter=0.
- last_grant=NUM_REQ-1, so requester 0 has first priority after reset.
- A frame interrupted by reset is not resent and produces no response pulse.

**Latencies**
- Grant cycle G: req_ready pulses in G.
- u_en=1 at G+1.
- Earliest possible return to IDLE for a write: G+4, which requires u_tx_busy high for one cycle only.
- Read response:
  - resp_valid rises the cycle after the edge that samples u_rx_ready=1 in RX_WAIT.
  - resp_data is valid in that same cycle.

**Throughput**
- Back-to-back requests from different requesters: a new grant is possible in the first IDLE cycle after the previous transaction completes. No idle bubble is required beyond that IDLE cycle.

**Timeout**
- resp_timeout pulses exactly TIMEOUT_CYCLES cycles after entry to RX_WAIT.

## Test plan
- **Reset:** hold rstn=0 mid-TX_WAIT.
  - Response required: all outputs at reset values immediately, and req_ready[0] wins the first grant after release even with both requesters valid.
- **Round-robin:** req_valid=2'b11 held continuously, writes only.
  - Response required: grants alternate 0,1,0,1, and u_din matches each owner's frame (0x00112345 for requester 0, 0x001A5678 for requester 1).
- **Read routing:** requester 1 sends a read; the UART model returns u_dout=0x00C3 20 cycles after TX ends.
  - Response required: resp_valid=2'b10 pulse for one cycle, resp_data=0x00C3, and no pulse on requester 0.
- **Timeout:** TIMEOUT_CYCLES=8, read from requester 0, no response.
  - Response required: resp_timeout=2'b01 exactly 8 cycles after entering RX_WAIT, then IDLE, and the next grant goes to requester 1.
- **Simultaneous events:** u_rx_ready=1 on the expiry cycle.
  - Response required: resp_valid pulses, resp_timeout stays 0.
- **Stray input:** stray u_rx_ready pulse during IDLE and during TX_WAIT.
  - Response required: no resp_valid, and resp_data unchanged.
